// File: rtl/nes_bus_pkg.sv
// Shared NES host-bus definitions: address map, DMA state encoding and bus-cycle parity.
package nes_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE,
      DONE
   } dma_state_t;

   typedef enum logic {
      GET = 1'b0,
      PUT = 1'b1
   } parity_t;

   localparam logic [15:0] ADDR_RAM     = 16'h0000;
   localparam logic [15:0] ADDR_PPU     = 16'h2000;
   localparam logic [15:0] ADDR_DMA     = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA controller and host-bus arbiter: halts the core on a $4014 write and
// copies one 256-byte page to the PPU OAM data port, then hands the bus back.
//
// state | meaning
// IDLE  | CPU owns the bus, waiting for a write to the trigger register
// HALT  | ready dropped, CPU still finishing writes until its first read cycle
// ALIGN | one dummy cycle so the first DMA read lands on a GET cycle
// READ  | GET cycle: read source byte {page,index}
// WRITE | PUT cycle: write latched byte to the OAM data port
// DONE  | last byte written, release the core on the next strobe
module oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] P_dma_reg  = ADDR_DMA,
   parameter logic [15:0] P_oam_port = ADDR_OAMDATA
) (
   input  logic        I_clock,
   input  logic        I_reset,
   input  logic        I_phy2,
   input  logic [15:0] I_cpu_addr,
   input  logic        I_cpu_rdwr,
   input  logic [7:0]  I_cpu_wr_data,
   output logic        O_cpu_ready,
   output logic [15:0] O_bus_addr,
   output logic        O_bus_rdwr,
   output logic [7:0]  O_bus_wr_data,
   input  logic [7:0]  I_bus_rd_data,
   output logic        O_dma_active
);

   dma_state_t state_q;
   parity_t    parity_q;
   logic [7:0] index_q;
   logic [7:0] index_d;
   logic [7:0] page_q;
   logic [7:0] data_q;
   logic       ready_q;
   logic       active_q;
   logic       trigger;

   assign trigger = (I_cpu_addr == P_dma_reg) && !I_cpu_rdwr;
   assign index_d = index_q + 8'd1;

   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         state_q  <= IDLE;
         parity_q <= GET;
         index_q  <= '0;
         page_q   <= '0;
         data_q   <= '0;
         ready_q  <= 1'b1;
         active_q <= 1'b0;
      end else if (I_phy2) begin
         parity_q <= (parity_q == GET) ? PUT : GET;
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  page_q  <= I_cpu_wr_data;
                  index_q <= '0;
                  ready_q <= 1'b0;
                  state_q <= HALT;
               end
            end
            HALT: begin
               // The first read strobe is where the core actually stalls.
               if (I_cpu_rdwr) begin
                  active_q <= 1'b1;
                  state_q  <= (parity_q == GET) ? ALIGN : READ;
               end
            end
            ALIGN: state_q <= READ;
            READ: begin
               data_q  <= I_bus_rd_data;
               state_q <= WRITE;
            end
            WRITE: begin
               index_q <= index_d;
               state_q <= (index_q == 8'hFF) ? DONE : READ;
            end
            DONE: begin
               ready_q  <= 1'b1;
               active_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      O_bus_addr    = I_cpu_addr;
      O_bus_rdwr    = I_cpu_rdwr;
      O_bus_wr_data = I_cpu_wr_data;
      case (state_q)
         READ: begin
            O_bus_addr = {page_q, index_q};
            O_bus_rdwr = 1'b1;
         end
         WRITE: begin
            O_bus_addr    = P_oam_port;
            O_bus_rdwr    = 1'b0;
            O_bus_wr_data = data_q;
         end
         default: ;
      endcase
   end

   assign O_cpu_ready  = ready_q;
   assign O_dma_active = active_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: the bench plays the core (one CPU cycle per two clocks)
// and a RAM whose byte at address a is a[7:0]^a[15:8]^5A.
module tb_oam_dma;
   import nes_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        phy2 = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_rdwr = 1'b1;
   logic [7:0]  cpu_wd = 8'h00;
   logic        ready;
   logic [15:0] bus_addr;
   logic        bus_rdwr;
   logic [7:0]  bus_wd;
   logic [7:0]  bus_rd;
   logic        active;

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   assign bus_rd = pat(bus_addr);

   oam_dma dut (
      .I_clock       (clk),
      .I_reset       (rst),
      .I_phy2        (phy2),
      .I_cpu_addr    (cpu_addr),
      .I_cpu_rdwr    (cpu_rdwr),
      .I_cpu_wr_data (cpu_wd),
      .O_cpu_ready   (ready),
      .O_bus_addr    (bus_addr),
      .O_bus_rdwr    (bus_rdwr),
      .O_bus_wr_data (bus_wd),
      .I_bus_rd_data (bus_rd),
      .O_dma_active  (active)
   );

   int          n_chk = 0;
   int          n_bad = 0;
   int          nstrb = 0;
   int          vis = 0;
   int          hit0 = 0;
   logic [15:0] rd_q[$];
   logic [7:0]  oam_q[$];
   logic        ready_a = 1'b1;
   logic        active_a = 1'b0;
   logic        smp_active = 1'b0;
   logic        smp_rdwr = 1'b1;
   logic [15:0] smp_addr = 16'h0000;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd);
      cpu_addr = a;
      cpu_rdwr = rw;
      cpu_wd   = wd;
      @(posedge clk); #1;
      phy2 = 1'b1;
      @(negedge clk);
      smp_addr   = bus_addr;
      smp_rdwr   = bus_rdwr;
      smp_active = active;
      if (!bus_rdwr && bus_addr == ADDR_OAMDATA) oam_q.push_back(bus_wd);
      if (bus_rdwr && active && bus_addr != cpu_addr) begin
         rd_q.push_back(bus_addr);
         if (bus_addr == ADDR_RAM) hit0++;
      end
      if (active && bus_addr == cpu_addr) vis++;
      @(posedge clk); #1;
      phy2     = 1'b0;
      ready_a  = ready;
      active_a = active;
      nstrb++;
   endtask

   task automatic clear_log();
      rd_q.delete();
      oam_q.delete();
      vis  = 0;
      hit0 = 0;
   endtask

   task automatic align_to(input int par);
      if ((nstrb % 2) != par) cpu_cycle(16'h8000, 1'b1, 8'h00);
   endtask

   task automatic run_dma(input logic [7:0] page, input int n_wr, input int force_at,
                          output int strobes, output logic first_act);
      clear_log();
      cpu_cycle(ADDR_DMA, 1'b0, page);
      check_val("trig_ready", 32'(ready_a), 32'd0);
      strobes = 0;
      for (int i = 0; i < n_wr; i++) begin
         cpu_cycle(16'h01FD - 16'(i), 1'b0, 8'hC0 + 8'(i));
         strobes++;
         check_val("pre_wr_bus", {14'd0, smp_active, smp_rdwr, smp_addr},
                   {14'd0, 1'b0, 1'b0, 16'h01FD - 16'(i)});
      end
      cpu_cycle(16'h8000, 1'b1, 8'h00);
      strobes++;
      first_act = smp_active;
      while (!ready_a && strobes < 600) begin
         if (strobes == force_at) cpu_cycle(ADDR_DMA, 1'b0, 8'h77);
         else cpu_cycle(16'h8000, 1'b1, 8'h00);
         strobes++;
      end
   endtask

   task automatic check_xfer(input string tag, input logic [7:0] page);
      int errs = 0;
      check_val({tag, "_nrd"}, 32'(rd_q.size()), 32'd256);
      check_val({tag, "_nwr"}, 32'(oam_q.size()), 32'd256);
      for (int k = 0; k < 256; k++) begin
         if (k < rd_q.size() && rd_q[k] != {page, 8'(k)}) errs++;
         if (k < oam_q.size() && oam_q[k] != pat({page, 8'(k)})) errs++;
      end
      check_val({tag, "_data"}, 32'(errs), 32'd0);
   endtask

   int   s;
   logic fa;
   int   n;

   initial begin
      // Trigger presented on the last clock that still sees reset.
      cpu_addr = ADDR_DMA; cpu_rdwr = 1'b0; cpu_wd = 8'h09; phy2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; phy2 = 1'b0; nstrb = 0;
      cpu_addr = 16'h1234; cpu_rdwr = 1'b1;
      @(posedge clk); #1;
      check_val("rst_ready", 32'(ready), 32'd1);
      check_val("rst_active", 32'(active), 32'd0);
      check_val("rst_pass_rd", {15'd0, bus_rdwr, bus_addr}, {15'd0, 1'b1, 16'h1234});
      cpu_addr = 16'h0300; cpu_rdwr = 1'b0; cpu_wd = 8'h5E; #1;
      check_val("rst_pass_wr", {7'd0, bus_rdwr, bus_addr, bus_wd}, {7'd0, 1'b0, 16'h0300, 8'h5E});
      cpu_cycle(16'h8000, 1'b1, 8'h00);
      check_val("rst_trig_ignored", 32'(ready_a), 32'd1);

      // 1: GET-aligned trigger
      align_to(0);
      run_dma(8'h02, 0, -1, s, fa);
      check_val("t1_strobes", 32'(s), 32'd514);
      check_val("t1_align_done", 32'(vis), 32'd1);
      check_val("t1_active_end", 32'(active_a), 32'd0);
      check_xfer("t1", 8'h02);

      // 2: PUT-aligned trigger
      align_to(1);
      run_dma(8'h02, 0, -1, s, fa);
      check_val("t2_strobes", 32'(s), 32'd515);
      check_val("t2_align_done", 32'(vis), 32'd2);
      check_xfer("t2", 8'h02);

      // 3: two CPU writes finish before the halt
      align_to(0);
      run_dma(8'h02, 2, -1, s, fa);
      check_val("t3_strobes", 32'(s), 32'd516);
      check_val("t3_first_rd_active", 32'(fa), 32'd0);
      check_val("t3_align_done", 32'(vis), 32'd1);
      check_xfer("t3", 8'h02);

      // 4: page $FF, no carry into page $00
      align_to(0);
      run_dma(8'hFF, 0, -1, s, fa);
      check_val("t4_strobes", 32'(s), 32'd514);
      check_xfer("t4", 8'hFF);
      check_val("t4_last_rd", 32'(rd_q.size() > 0 ? rd_q[rd_q.size() - 1] : 16'h0000), 32'h0000FFFF);
      check_val("t4_hit0000", 32'(hit0), 32'd0);

      // 5: reset at byte 100
      align_to(0);
      clear_log();
      cpu_cycle(ADDR_DMA, 1'b0, 8'h03);
      n = 0;
      while (oam_q.size() < 100 && n < 400) begin
         cpu_cycle(16'h8000, 1'b1, 8'h00);
         n++;
      end
      check_val("t5_reach100", 32'(oam_q.size()), 32'd100);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; nstrb = 0;
      check_val("t5_ready", 32'(ready), 32'd1);
      check_val("t5_active", 32'(active), 32'd0);
      cpu_addr = 16'h1234; cpu_rdwr = 1'b1; #1;
      check_val("t5_bus_cpu", {15'd0, bus_rdwr, bus_addr}, {15'd0, 1'b1, 16'h1234});
      repeat (4) cpu_cycle(16'h8000, 1'b1, 8'h00);
      check_val("t5_no_oam_after", 32'(oam_q.size()), 32'd100);
      run_dma(8'h05, 0, -1, s, fa);
      check_val("t5_restart_strobes", 32'(s), 32'd514);
      check_xfer("t5", 8'h05);

      // 6: trigger register written mid-transfer
      align_to(0);
      run_dma(8'h06, 0, 50, s, fa);
      check_val("t6_strobes", 32'(s), 32'd514);
      check_xfer("t6", 8'h06);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
